noc_switch_rr: RTL and testbench

Parametrised successor to the 5-port NoC router switch. It is a registered crossbar with NPORTS input and NPORTS output channels and a configurable flit width. Each output has its own round-robin arbiter and wormhole lock, so a multi-flit packet holds its output until its tail flit passes. It sits at the core of each router tile, between the input buffers and the link drivers.

---
 rtl/noc_switch_rr.sv | 117 +++++++++++
 tb/tb_noc_switch_rr.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/noc_switch_rr.sv
// Registered NPORTS x NPORTS crossbar. Each output has its own round-robin
// arbiter and a wormhole lock that is held from a packet's head flit to its tail flit.
module noc_switch_rr #(
  parameter int DATA_W = 8,
  parameter int NPORTS = 5,
  parameter int SEL_W  = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NPORTS*DATA_W-1:0] in_data,
  input  logic [NPORTS*SEL_W-1:0]  in_req,
  input  logic [NPORTS-1:0]        in_last,
  output logic [NPORTS-1:0]        in_grant,
  output logic [NPORTS*DATA_W-1:0] out_data,
  output logic [NPORTS-1:0]        out_valid
);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  state_e            state_q [NPORTS];
  state_e            state_d [NPORTS];
  logic [SEL_W-1:0]  owner_q [NPORTS];
  logic [SEL_W-1:0]  owner_d [NPORTS];
  logic [SEL_W-1:0]  ptr_q   [NPORTS];
  logic [SEL_W-1:0]  ptr_d   [NPORTS];
  logic [DATA_W-1:0] data_q  [NPORTS];
  logic [DATA_W-1:0] data_d  [NPORTS];
  logic [NPORTS-1:0] valid_q;
  logic [NPORTS-1:0] valid_d;

  logic [SEL_W-1:0]  req_a   [NPORTS];
  logic [DATA_W-1:0] din_a   [NPORTS];
  logic [NPORTS-1:0] hit;
  logic [SEL_W-1:0]  src     [NPORTS];
  logic [NPORTS-1:0] grant;

  for (genvar g = 0; g < NPORTS; g++) begin : g_port
    assign req_a[g]                      = in_req[g*SEL_W +: SEL_W];
    assign din_a[g]                      = in_data[g*DATA_W +: DATA_W];
    assign out_data[g*DATA_W +: DATA_W]  = data_q[g];
  end

  assign out_valid = valid_q;
  assign in_grant  = rst ? grant : '0;

  always_comb begin
    int idx;
    idx   = 0;
    grant = '0;
    hit   = '0;
    valid_d = '0;
    for (int o = 0; o < NPORTS; o++) begin
      state_d[o] = state_q[o];
      owner_d[o] = owner_q[o];
      ptr_d[o]   = ptr_q[o];
      data_d[o]  = data_q[o];
      src[o]     = '0;
    end

    for (int o = 0; o < NPORTS; o++) begin
      if (state_q[o] == ST_LOCKED) begin
        // A locked output only serves its owner; the pointer is left alone.
        if (req_a[owner_q[o]] == SEL_W'(o)) begin
          hit[o] = 1'b1;
          src[o] = owner_q[o];
          if (in_last[owner_q[o]]) state_d[o] = ST_IDLE;
        end
      end else begin
        for (int k = 0; k < NPORTS; k++) begin
          idx = int'(ptr_q[o]) + k;
          if (idx >= NPORTS) idx = idx - NPORTS;
          if (!hit[o] && req_a[idx] == SEL_W'(o)) begin
            hit[o] = 1'b1;
            src[o] = SEL_W'(idx);
          end
        end
        if (hit[o]) begin
          ptr_d[o] = (int'(src[o]) == NPORTS-1) ? '0 : src[o] + 1'b1;
          if (!in_last[src[o]]) begin
            state_d[o] = ST_LOCKED;
            owner_d[o] = src[o];
          end
        end
      end

      if (hit[o]) begin
        grant[src[o]] = 1'b1;
        data_d[o]     = din_a[src[o]];
        valid_d[o]    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int o = 0; o < NPORTS; o++) begin
        state_q[o] <= ST_IDLE;
        owner_q[o] <= '0;
        ptr_q[o]   <= '0;
        data_q[o]  <= '0;
      end
      valid_q <= '0;
    end else begin
      for (int o = 0; o < NPORTS; o++) begin
        state_q[o] <= state_d[o];
        owner_q[o] <= owner_d[o];
        ptr_q[o]   <= ptr_d[o];
        data_q[o]  <= data_d[o];
      end
      valid_q <= valid_d;
    end
  end

endmodule

// File: tb/tb_noc_switch_rr.sv
// Scoreboard bench for noc_switch_rr: grants are checked in-cycle, and the
// expected output flits are queued and compared one cycle later.
module tb_noc_switch_rr;

  localparam int DATA_W = 8;
  localparam int NPORTS = 5;
  localparam int SEL_W  = 3;
  localparam logic [SEL_W-1:0] IDLE_REQ = '1;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NPORTS*DATA_W-1:0] in_data;
  logic [NPORTS*SEL_W-1:0]  in_req;
  logic [NPORTS-1:0]        in_last;
  logic [NPORTS-1:0]        in_grant;
  logic [NPORTS*DATA_W-1:0] out_data;
  logic [NPORTS-1:0]        out_valid;

  noc_switch_rr #(.DATA_W(DATA_W), .NPORTS(NPORTS), .SEL_W(SEL_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_req    (in_req),
    .in_last   (in_last),
    .in_grant  (in_grant),
    .out_data  (out_data),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NPORTS-1:0]        valid;
    logic [NPORTS*DATA_W-1:0] data;
  } exp_t;

  exp_t              sb_q[$];
  int                test_count = 0;
  int                fail_count = 0;
  logic [SEL_W-1:0]  req      [NPORTS];
  logic [DATA_W-1:0] dat      [NPORTS];
  logic [NPORTS-1:0] lst;
  logic [DATA_W-1:0] hold_data[NPORTS];

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    test_count++;
    if (obs !== expv) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, expv);
    end
  endtask

  task automatic idleAll();
    for (int i = 0; i < NPORTS; i++) begin
      req[i] = IDLE_REQ;
      dat[i] = '0;
    end
    lst = '1;
  endtask

  task automatic driveInputs();
    for (int i = 0; i < NPORTS; i++) begin
      in_req[i*SEL_W +: SEL_W]   = req[i];
      in_data[i*DATA_W +: DATA_W] = dat[i];
    end
    in_last = lst;
  endtask

  task automatic clearHold();
    for (int o = 0; o < NPORTS; o++) hold_data[o] = '0;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, " grant"}, 64'(in_grant), 64'(0));
    checkOutput({tag, " valid"}, 64'(out_valid), 64'(0));
    checkOutput({tag, " data"},  64'(out_data),  64'(0));
  endtask

  // One cycle: drive, check grant, queue expected outputs, clock, compare.
  task automatic applyStimulus(input string tag, input logic [NPORTS-1:0] exp_grant);
    exp_t e;
    driveInputs();
    #1;
    checkOutput({tag, " grant"}, 64'(in_grant), 64'(exp_grant));
    e.valid = '0;
    for (int i = 0; i < NPORTS; i++) begin
      if (exp_grant[i]) begin
        e.valid[req[i]]    = 1'b1;
        hold_data[req[i]]  = dat[i];
      end
    end
    for (int o = 0; o < NPORTS; o++) e.data[o*DATA_W +: DATA_W] = hold_data[o];
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    checkOutput({tag, " valid"}, 64'(out_valid), 64'(e.valid));
    for (int o = 0; o < NPORTS; o++)
      checkOutput($sformatf("%s data%0d", tag, o),
                  64'(out_data[o*DATA_W +: DATA_W]), 64'(e.data[o*DATA_W +: DATA_W]));
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b0;
    clearHold();
    idleAll();
    driveInputs();
    #3;
    checkResetState("reset");
    req[0] = 3'd0;
    dat[0] = 8'h99;
    driveInputs();
    #1;
    checkOutput("reset forced grant", 64'(in_grant), 64'(0));
    idleAll();
    driveInputs();
    @(posedge clk);
    @(posedge clk);
    #1;
    checkResetState("reset held");
    rst = 1'b1;

    applyStimulus("idle0", 5'b00000);
    applyStimulus("idle1", 5'b00000);

    idleAll(); req[0] = 3'd0; dat[0] = 8'h02;
    applyStimulus("single", 5'b00001);
    idleAll();
    applyStimulus("single after", 5'b00000);

    idleAll(); req[1] = 3'd2; dat[1] = 8'h03; req[3] = 3'd4; dat[3] = 8'h07;
    applyStimulus("parallel", 5'b01010);

    // W pointer sits at 4 after the parallel transfer from S.
    idleAll();
    req[0] = 3'd4; dat[0] = 8'h10;
    req[1] = 3'd4; dat[1] = 8'h11;
    req[2] = 3'd4; dat[2] = 8'h12;
    applyStimulus("rr L", 5'b00001);
    applyStimulus("rr N", 5'b00010);
    applyStimulus("rr E", 5'b00100);
    req[3] = 3'd4; dat[3] = 8'h13;
    req[4] = 3'd4; dat[4] = 8'h14;
    applyStimulus("rr S", 5'b01000);
    applyStimulus("rr W", 5'b10000);
    applyStimulus("rr wrap L", 5'b00001);

    idleAll();
    req[2] = 3'd1; dat[2] = 8'hA1; lst[2] = 1'b0;
    req[3] = 3'd1; dat[3] = 8'h55;
    applyStimulus("worm A1", 5'b00100);
    dat[2] = 8'hA2;
    applyStimulus("worm A2", 5'b00100);
    dat[2] = 8'hA3; lst[2] = 1'b1;
    applyStimulus("worm A3", 5'b00100);
    req[2] = IDLE_REQ;
    applyStimulus("worm S", 5'b01000);

    // N pointer is 4 here, so E (index 2) is reached before S (index 3).
    idleAll();
    req[2] = 3'd1; dat[2] = 8'hB1; lst[2] = 1'b0;
    req[3] = 3'd1; dat[3] = 8'h66;
    applyStimulus("stall B1", 5'b00100);
    req[2] = IDLE_REQ;
    applyStimulus("stall 1", 5'b00000);
    applyStimulus("stall 2", 5'b00000);
    rst = 1'b0;
    #1;
    checkResetState("mid reset");
    clearHold();
    rst = 1'b1;
    #1;
    applyStimulus("after reset S", 5'b01000);
    idleAll();
    applyStimulus("final idle", 5'b00000);

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
